vram_rgb_buffer: RTL



---
 rtl/vram_pkg.sv | 25 ++
 rtl/vram_rgb_buffer_if.sv | 39 +++
 rtl/vram_bank.sv | 44 ++++
 rtl/vram_rgb_buffer.sv | 99 +++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// vram_pkg: shared types and constants for the RGB video RAM.
//   fill_state_e  - fill engine states (IDLE/FILL/DONE), fixed 2-bit encoding
//   CH_R/G/B      - channel slot index inside a packed {R,G,B} word
//   word_w()      - width of one packed pixel word for a given channel width
package vram_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    FILL = ST_FILL,
    DONE = ST_DONE
  } fill_state_e;

  localparam int CH_R = 2;
  localparam int CH_G = 1;
  localparam int CH_B = 0;

  function automatic int word_w(input int color_w);
    return 3 * color_w;
  endfunction

endpackage

// File: rtl/vram_rgb_buffer_if.sv
// vram_rgb_buffer_if: pixel-fetch, draw-write and fill-control signals.
//   slave  - the buffer (drives pixels, rd_valid, wr_ack, fill_busy/done)
//   master - the VGA front end / pixel producer
interface vram_rgb_buffer_if #(
  parameter int ADDR_W  = 14,
  parameter int COLOR_W = 1
);
  import vram_pkg::*;

  localparam int WORD_W = word_w(COLOR_W);

  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic [COLOR_W-1:0]  r_pixel;
  logic [COLOR_W-1:0]  g_pixel;
  logic [COLOR_W-1:0]  b_pixel;
  logic                rd_valid;

  logic                wr_req;
  logic [ADDR_W-1:0]   wr_addr;
  logic [WORD_W-1:0]   wr_data;
  logic                wr_ack;

  logic                fill_start;
  logic [WORD_W-1:0]   fill_color;
  logic                fill_busy;
  logic                fill_done;

  modport slave (
    input  rd_en, rd_addr, wr_req, wr_addr, wr_data, fill_start, fill_color,
    output r_pixel, g_pixel, b_pixel, rd_valid, wr_ack, fill_busy, fill_done
  );

  modport master (
    output rd_en, rd_addr, wr_req, wr_addr, wr_data, fill_start, fill_color,
    input  r_pixel, g_pixel, b_pixel, rd_valid, wr_ack, fill_busy, fill_done
  );

endinterface

// File: rtl/vram_bank.sv
// vram_bank: simple dual-port RAM, DEPTH x DATA_W.
//   clk, reset         - clock, sync active-high reset (output register only)
//   we_i/waddr_i/wdata_i - write port; out-of-range addresses are dropped
//   re_i/raddr_i       - read port; registered, read-first
//   rdata_o            - read data; loads 0 for out-of-range addresses
module vram_bank #(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 12288,
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  logic w_ok, r_ok;
  assign w_ok = ({1'b0, waddr_i} < DEPTH_L);
  assign r_ok = ({1'b0, raddr_i} < DEPTH_L);

  // Contents are not reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i && w_ok) mem[waddr_i[IDX_W-1:0]] <= wdata_i;
  end

  // Non-blocking read of mem gives read-first on a same-address collision.
  always_ff @(posedge clk) begin
    if (reset)     rdata_q <= '0;
    else if (re_i) rdata_q <= r_ok ? mem[raddr_i[IDX_W-1:0]] : '0;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vram_rgb_buffer.sv
// vram_rgb_buffer: writable RGB video RAM with hardware fill engine.
//   clk, reset - single clock, sync active-high reset
//   bus        - vram_rgb_buffer_if.slave: read port (rd_en/rd_addr ->
//                r/g/b_pixel, rd_valid), write handshake (wr_req/addr/data ->
//                wr_ack), fill control (fill_start/color -> fill_busy/done)
// The fill engine owns the write port for DEPTH+1 cycles (FILL then DONE);
// the read port is never blocked.
module vram_rgb_buffer
  import vram_pkg::*;
#(
  parameter int ADDR_W  = 14,
  parameter int DEPTH   = 12288,
  parameter int COLOR_W = 1
) (
  input  logic              clk,
  input  logic              reset,
  vram_rgb_buffer_if.slave  bus
);

  localparam int WORD_W = word_w(COLOR_W);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  fill_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0] color_q, color_d;
  logic              rd_valid_q;

  logic              wr_ack;
  logic              fill_we;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] rdata;

  // A fill request in the same cycle beats a pending write.
  assign wr_ack  = bus.wr_req & (state_q == IDLE) & ~bus.fill_start;
  assign fill_we = (state_q == FILL);

  // Suppress writes on a reset edge so an aborted fill stops cleanly.
  assign mem_we    = ~reset & (wr_ack | fill_we);
  assign mem_waddr = fill_we ? cnt_q   : bus.wr_addr;
  assign mem_wdata = fill_we ? color_q : bus.wr_data;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    case (state_q)
      IDLE: if (bus.fill_start) begin
        state_d = FILL;
        cnt_d   = '0;
        color_d = bus.fill_color;
      end
      // Counter holds at the last address rather than wrapping.
      FILL: if (cnt_q == LAST) state_d = DONE;
            else               cnt_d   = cnt_q + 1'b1;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      color_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      color_q    <= color_d;
      rd_valid_q <= bus.rd_en;
    end
  end

  vram_bank #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .DATA_W (WORD_W)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .re_i    (bus.rd_en),
    .raddr_i (bus.rd_addr),
    .rdata_o (rdata)
  );

  assign bus.r_pixel   = rdata[CH_R*COLOR_W +: COLOR_W];
  assign bus.g_pixel   = rdata[CH_G*COLOR_W +: COLOR_W];
  assign bus.b_pixel   = rdata[CH_B*COLOR_W +: COLOR_W];
  assign bus.rd_valid  = rd_valid_q;
  assign bus.wr_ack    = wr_ack;
  assign bus.fill_busy = (state_q == FILL);
  assign bus.fill_done = (state_q == DONE);

endmodule
